// File: rtl/fdtd_pkg.sv
// Shared types and defaults for the FDTD accelerator control path.
package fdtd_pkg;

  localparam int unsigned STEP_W_DEF    = 16;
  localparam int unsigned TIMEOUT_W_DEF = 20;

  typedef enum logic [2:0] {
    StIdle,
    StBuf,
    StCalc,
    StWrt,
    StNext,
    StDone,
    StErr
  } sched_state_e;

  typedef enum logic [1:0] {
    PH_HY  = 2'd0,
    PH_EZ  = 2'd1,
    PH_SRC = 2'd2
  } fdtd_phase_e;

  // Phase order within one time step: HY -> EZ -> SRC.
  function automatic fdtd_phase_e next_phase(input fdtd_phase_e ph);
    case (ph)
      PH_HY:   next_phase = PH_EZ;
      PH_EZ:   next_phase = PH_SRC;
      default: next_phase = PH_HY;
    endcase
  endfunction

endpackage

// File: rtl/fdtd_wdog.sv
// Wait-state watchdog: counts cycles spent in a wait state and flags all-ones.
module fdtd_wdog
  import fdtd_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TIMEOUT_W-1:0] r_cnt;

  assign expired_o = &r_cnt;

  // Counter holds the number of cycles already spent in the current wait state.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && !expired_o) begin
      r_cnt <= r_cnt + TIMEOUT_W'(1);
    end
  end

endmodule

// File: rtl/fdtd_step_sched.sv
// Time-step sequencer: runs HY/EZ/SRC phases (buffer, calc, write-back) per step.
module fdtd_step_sched
  import fdtd_pkg::*;
#(
  parameter int unsigned STEP_W    = STEP_W_DEF,
  parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [STEP_W-1:0] steps_i,
  input  logic              int_en_i,
  input  logic              clr_int_i,
  output logic              buf_start_o,
  input  logic              buf_done_i,
  output logic              calc_start_o,
  input  logic              calc_done_i,
  output logic              wrt_start_o,
  input  logic              wrt_done_i,
  output logic [1:0]        phase_o,
  output logic [STEP_W-1:0] step_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              int_pending_o,
  output logic              int_o
);

  sched_state_e      r_state;
  fdtd_phase_e       r_phase;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] r_steps;
  logic              r_buf_start;
  logic              r_calc_start;
  logic              r_wrt_start;
  logic              r_done;
  logic              r_err;
  logic              r_int;

  logic w_wait;
  logic w_first;
  logic w_leave;
  logic w_wd_clr;
  logic w_expired;
  logic w_last_step;

  assign w_wait  = (r_state == StBuf) || (r_state == StCalc) || (r_state == StWrt);
  // The start-pulse cycle of a wait state never samples its done input.
  assign w_first = r_buf_start || r_calc_start || r_wrt_start;
  assign w_leave = !w_first && (((r_state == StBuf)  && buf_done_i) ||
                                ((r_state == StCalc) && calc_done_i) ||
                                ((r_state == StWrt)  && wrt_done_i));
  // Clearing on the leaving cycle makes the count start at 0 in the next state.
  assign w_wd_clr    = !w_wait || w_leave || abort_i;
  assign w_last_step = (r_step == (r_steps - STEP_W'(1)));

  fdtd_wdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_wdog (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .clr_i     (w_wd_clr),
    .en_i      (w_wait),
    .expired_o (w_expired)
  );

  // Sequencer FSM with registered pulses, step/phase tracking and sticky flags.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state      <= StIdle;
      r_phase      <= PH_HY;
      r_step       <= '0;
      r_steps      <= '0;
      r_buf_start  <= 1'b0;
      r_calc_start <= 1'b0;
      r_wrt_start  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_int        <= 1'b0;
    end else begin
      r_buf_start  <= 1'b0;
      r_calc_start <= 1'b0;
      r_wrt_start  <= 1'b0;
      r_done       <= 1'b0;
      // Placed before the state logic so a same-cycle set wins.
      if (clr_int_i) begin
        r_int <= 1'b0;
        r_err <= 1'b0;
      end
      if (abort_i && (r_state != StIdle)) begin
        r_state <= StIdle;
      end else begin
        case (r_state)
          StIdle: begin
            if (start_i) begin
              r_err   <= 1'b0;
              r_steps <= steps_i;
              r_step  <= '0;
              r_phase <= PH_HY;
              if (steps_i != '0) begin
                r_state     <= StBuf;
                r_buf_start <= 1'b1;
              end else begin
                r_state <= StDone;
                r_done  <= 1'b1;
                r_int   <= 1'b1;
              end
            end
          end
          StBuf: begin
            if (!r_buf_start && buf_done_i) begin
              r_state      <= StCalc;
              r_calc_start <= 1'b1;
            end else if (w_expired) begin
              r_state <= StErr;
              r_err   <= 1'b1;
              r_int   <= 1'b1;
            end
          end
          StCalc: begin
            if (!r_calc_start && calc_done_i) begin
              r_state     <= StWrt;
              r_wrt_start <= 1'b1;
            end else if (w_expired) begin
              r_state <= StErr;
              r_err   <= 1'b1;
              r_int   <= 1'b1;
            end
          end
          StWrt: begin
            if (!r_wrt_start && wrt_done_i) begin
              r_state <= StNext;
            end else if (w_expired) begin
              r_state <= StErr;
              r_err   <= 1'b1;
              r_int   <= 1'b1;
            end
          end
          StNext: begin
            if (r_phase != PH_SRC) begin
              r_phase     <= next_phase(r_phase);
              r_state     <= StBuf;
              r_buf_start <= 1'b1;
            end else if (w_last_step) begin
              r_state <= StDone;
              r_done  <= 1'b1;
              r_int   <= 1'b1;
            end else begin
              r_step      <= r_step + STEP_W'(1);
              r_phase     <= PH_HY;
              r_state     <= StBuf;
              r_buf_start <= 1'b1;
            end
          end
          StDone:  r_state <= StIdle;
          StErr:   r_state <= StIdle;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign buf_start_o   = r_buf_start;
  assign calc_start_o  = r_calc_start;
  assign wrt_start_o   = r_wrt_start;
  assign phase_o       = r_phase;
  assign step_o        = r_step;
  assign busy_o        = (r_state != StIdle);
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign int_pending_o = r_int;
  assign int_o         = r_int & int_en_i;

endmodule
